// File: rtl/fetch_defs.sv
// Shared fetch definitions: next-PC select encoding, default vectors and the
// redirect priority function.
package fetch_defs;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_EXC    = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR   = 32'h0000_0080;

  // Exception beats jump beats branch; jump+branch therefore resolves to jump.
  function automatic pc_sel_e pick_sel(input logic exc, input logic jmp, input logic br);
    if (exc)      return SEL_EXC;
    else if (jmp) return SEL_JUMP;
    else if (br)  return SEL_BRANCH;
    else          return SEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO decoupling fetch from decode. The head is read
// combinationally; push and pop may both happen on a full queue.
module fetch_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, picks the next PC and buffers
// fetched instructions in a queue drained by decode via valid/ready.
module fetch_unit #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PC_STEP      = 4,
  parameter logic [31:0] RESET_VECTOR = fetch_defs::RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = fetch_defs::EXC_VECTOR,
  localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Exception,
  input  logic                  Jump,
  input  logic                  Branch,
  input  logic [ADDR_WIDTH-1:0] JumpDest,
  input  logic [ADDR_WIDTH-1:0] BranchDest,
  output logic [ADDR_WIDTH-1:0] ImAddr,
  input  logic [DATA_WIDTH-1:0] ImData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic [ADDR_WIDTH-1:0] PC,
  output logic [ADDR_WIDTH-1:0] PCI,
  output logic [CW-1:0]         Count
);

  localparam int unsigned QW = DATA_WIDTH + 2 * ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] fpc;
  logic [ADDR_WIDTH-1:0] fpc_inc;
  logic [ADDR_WIDTH-1:0] fpc_next;
  logic                  redirect;
  logic                  push;
  logic                  pop;
  logic [QW-1:0]         q_din;
  logic [QW-1:0]         q_dout;
  fetch_defs::pc_sel_e   sel;

  assign redirect = Exception | Jump | Branch;
  assign OutValid = (Count != '0) & ~redirect;
  assign pop      = OutValid & OutReady;
  // A pop frees the slot this cycle, so a full queue keeps fetching.
  assign push     = ~redirect & ((Count < CW'(DEPTH)) | pop);
  assign fpc_inc  = fpc + ADDR_WIDTH'(PC_STEP);
  assign sel      = fetch_defs::pick_sel(Exception, Jump, Branch);

  // Next-PC mux
  always_comb begin
    fpc_next = fpc_inc;
    case (sel)
      fetch_defs::SEL_EXC:    fpc_next = ADDR_WIDTH'(EXC_VECTOR);
      fetch_defs::SEL_JUMP:   fpc_next = JumpDest;
      fetch_defs::SEL_BRANCH: fpc_next = BranchDest;
      default:                fpc_next = fpc_inc;
    endcase
  end

  // Fetch PC holds whenever the queue cannot accept and nothing redirects.
  always_ff @(posedge Clock) begin
    if (Reset)                 fpc <= ADDR_WIDTH'(RESET_VECTOR);
    else if (redirect || push) fpc <= fpc_next;
  end

  assign ImAddr = fpc;
  assign q_din  = {ImData, fpc, fpc_inc};

  fetch_queue #(
    .WIDTH (QW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (Clock),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   (q_din),
    .dout  (q_dout),
    .count (Count)
  );

  assign {Instruction, PC, PCI} = q_dout;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory returns word = address.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exc = 1'b0;
  logic        jmp = 1'b0;
  logic        br  = 1'b0;
  logic [31:0] jdest = '0;
  logic [31:0] bdest = '0;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pci;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign im_data = im_addr;

  fetch_unit dut (
    .Clock       (clk),
    .Reset       (rst),
    .Exception   (exc),
    .Jump        (jmp),
    .Branch      (br),
    .JumpDest    (jdest),
    .BranchDest  (bdest),
    .ImAddr      (im_addr),
    .ImData      (im_data),
    .OutValid    (out_valid),
    .OutReady    (out_ready),
    .Instruction (instr),
    .PC          (pc),
    .PCI         (pci),
    .Count       (count)
  );

  // Advance one clock; returns at the next falling edge.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; exc = 1'b0; jmp = 1'b0; br = 1'b0; out_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_checks++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL reset_imaddr: got %h expected 00000000", im_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, out_valid); end
      n_checks++; if (pc !== 32'(4 * i) || instr !== 32'(4 * i) || pci !== 32'(4 * i + 4)) begin
        n_fail++; $display("FAIL seq_head[%0d]: got pc=%h instr=%h pci=%h expected pc=instr=%h pci=%h", i, pc, instr, pci, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall_and_drain();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) next_cycle();
    #1;
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL stall_count: got %0d expected 4", count); end
    n_checks++; if (im_addr !== 32'h10) begin n_fail++; $display("FAIL stall_imaddr: got %h expected 00000010", im_addr); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b1 || pc !== 32'(4 * i) || instr !== 32'(4 * i)) begin
        n_fail++; $display("FAIL drain_head[%0d]: got valid=%b pc=%h instr=%h expected valid=1 pc=instr=%h", i, out_valid, pc, instr, 32'(4 * i));
      end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count[%0d]: got %0d expected 4", i, count); end
      next_cycle();
    end
  endtask

  task automatic test_branch();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) next_cycle();
    #1;
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL br_pre_count: got %0d expected 3", count); end
    br = 1'b1; bdest = 32'h200; out_ready = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid_same_cycle: got %b expected 0", out_valid); end
    next_cycle();
    br = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL br_flush_count: got %0d expected 0", count); end
    n_checks++; if (im_addr !== 32'h200) begin n_fail++; $display("FAIL br_imaddr: got %h expected 00000200", im_addr); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid_n1: got %b expected 0", out_valid); end
    next_cycle(); #1;
    n_checks++; if (out_valid !== 1'b1 || pc !== 32'h200 || instr !== 32'h200 || pci !== 32'h204) begin
      n_fail++; $display("FAIL br_head: got valid=%b pc=%h instr=%h pci=%h expected 1 200 200 204", out_valid, pc, instr, pci);
    end
  endtask

  task automatic test_priority();
    do_reset();
    out_ready = 1'b1;
    next_cycle();
    jmp = 1'b1; br = 1'b1; jdest = 32'h400; bdest = 32'h200;
    next_cycle();
    jmp = 1'b0; br = 1'b0;
    #1;
    n_checks++; if (im_addr !== 32'h400) begin n_fail++; $display("FAIL prio_jump_over_branch: got %h expected 00000400", im_addr); end
    exc = 1'b1; jmp = 1'b1;
    next_cycle();
    exc = 1'b0; jmp = 1'b0;
    #1;
    n_checks++; if (im_addr !== 32'h80) begin n_fail++; $display("FAIL prio_exc_over_jump: got %h expected 00000080", im_addr); end
    next_cycle(); #1;
    n_checks++; if (out_valid !== 1'b1 || pc !== 32'h80) begin n_fail++; $display("FAIL prio_exc_head: got valid=%b pc=%h expected 1 00000080", out_valid, pc); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL rmid_pre_count: got %0d expected 2", count); end
    rst = 1'b1; out_ready = 1'b1;
    next_cycle();
    rst = 1'b0; out_ready = 1'b0;
    #1;
    n_checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_flush: got count=%0d valid=%b expected 0 0", count, out_valid); end
    n_checks++; if (im_addr !== 32'h0) begin n_fail++; $display("FAIL rmid_imaddr: got %h expected 00000000", im_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1;
    jmp = 1'b1; jdest = 32'hFFFF_FFF8;
    next_cycle();
    jmp = 1'b0;
    next_cycle(); #1;
    n_checks++; if (im_addr !== 32'hFFFF_FFFC || pc !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_a: got imaddr=%h pc=%h expected fffffffc fffffff8", im_addr, pc); end
    next_cycle(); #1;
    n_checks++; if (im_addr !== 32'h0 || pc !== 32'hFFFF_FFFC || pci !== 32'h0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_b: got imaddr=%h pc=%h pci=%h valid=%b expected 0 fffffffc 0 1", im_addr, pc, pci, out_valid);
    end
    next_cycle(); #1;
    n_checks++; if (out_valid !== 1'b1 || pc !== 32'h0 || instr !== 32'h0) begin n_fail++; $display("FAIL wrap_c: got valid=%b pc=%h instr=%h expected 1 0 0", out_valid, pc, instr); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall_and_drain();
    test_branch();
    test_priority();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
